// File: rtl/drrip_dueling_ctrl.sv
// DRRIP replacement controller: per-set RRPV table, SRRIP/BRRIP set dueling via
// leader sets and a saturating PSEL, sequential victim search with one aging step per cycle.
module drrip_dueling_ctrl #(
   parameter int unsigned WAYS        = 4,
   parameter int unsigned INDEX_WIDTH = 6,
   parameter int unsigned M           = 2,
   parameter int unsigned PSEL_WIDTH  = 10,
   parameter int unsigned BIP_PERIOD  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   halt,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [INDEX_WIDTH-1:0] req_index,
   input  logic                   req_hit,
   input  logic [WAYS-1:0]        req_hit_way,
   output logic                   resp_valid,
   output logic [WAYS-1:0]        resp_victim_way,
   output logic                   resp_policy,
   output logic [1:0]             resp_leader,
   output logic [PSEL_WIDTH-1:0]  psel_o
);

   localparam int unsigned SETS  = 2 ** INDEX_WIDTH;
   localparam int unsigned K     = INDEX_WIDTH / 2;
   localparam int unsigned BIP_W = (BIP_PERIOD > 1) ? $clog2(BIP_PERIOD) : 1;

   localparam logic [M-1:0]          RMAX      = {M{1'b1}};
   localparam logic [M-1:0]          RINS      = M'(RMAX - 1);
   localparam logic [PSEL_WIDTH-1:0] PMAX      = {PSEL_WIDTH{1'b1}};
   localparam logic [PSEL_WIDTH-1:0] PSEL_INIT = {1'b0, {(PSEL_WIDTH-1){1'b1}}};
   localparam logic [BIP_W-1:0]      BIP_LAST  = BIP_W'(BIP_PERIOD - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

   state_t                       r_state;
   logic [WAYS-1:0][M-1:0]       r_rrpv [SETS];
   logic [PSEL_WIDTH-1:0]        r_psel;
   logic [BIP_W-1:0]             r_bip;
   logic [INDEX_WIDTH-1:0]       r_index;
   logic                         r_policy;
   logic [1:0]                   r_leader;
   logic [WAYS-1:0]              r_victim;
   logic                         r_resp_valid;
   logic [WAYS-1:0]              r_resp_victim;
   logic                         r_resp_policy;
   logic [1:0]                   r_resp_leader;

   state_t                       w_state_nxt;
   logic                         w_accept;
   logic                         w_hit_wr;
   logic                         w_ins_wr;
   logic                         w_age;
   logic [M-1:0]                 w_ins_val;
   logic [PSEL_WIDTH-1:0]        w_psel_nxt;
   logic [BIP_W-1:0]             w_bip_nxt;
   logic [K-1:0]                 w_c;
   logic [K-1:0]                 w_o;
   logic [1:0]                   w_leader_in;
   logic                         w_policy_in;
   logic [WAYS-1:0][M-1:0]       w_set;
   logic                         w_found;
   logic [WAYS-1:0]              w_vic;

   assign req_ready       = (r_state == ST_IDLE) && !halt;
   assign resp_valid      = r_resp_valid;
   assign resp_victim_way = r_resp_victim;
   assign resp_policy     = r_resp_policy;
   assign resp_leader     = r_resp_leader;
   assign psel_o          = r_psel;

   // Leader-set classification from the two halves of the index
   assign w_c = req_index[INDEX_WIDTH-1 -: K];
   assign w_o = req_index[K-1:0];

   always_comb begin
      w_leader_in = 2'd0;
      if (w_c == w_o)       w_leader_in = 2'd1;
      else if (w_c == ~w_o) w_leader_in = 2'd2;
      w_policy_in = r_psel[PSEL_WIDTH-1];
      if (w_leader_in == 2'd1)      w_policy_in = 1'b0;
      else if (w_leader_in == 2'd2) w_policy_in = 1'b1;
   end

   // Lowest-numbered way at RMAX in the latched set
   assign w_set = r_rrpv[r_index];

   always_comb begin
      w_found = 1'b0;
      w_vic   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_set[w] == RMAX) begin
            w_found  = 1'b1;
            w_vic    = '0;
            w_vic[w] = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_hit_wr    = 1'b0;
      w_ins_wr    = 1'b0;
      w_age       = 1'b0;
      w_ins_val   = RINS;
      w_psel_nxt  = r_psel;
      w_bip_nxt   = r_bip;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               w_accept = 1'b1;
               if (req_hit) begin
                  w_hit_wr    = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (w_found) begin
               w_ins_wr    = 1'b1;
               w_state_nxt = ST_DONE;
               if (r_policy) begin
                  if (r_bip != '0) w_ins_val = RMAX;
                  w_bip_nxt = (r_bip == BIP_LAST) ? '0 : r_bip + BIP_W'(1);
               end
               if (r_leader == 2'd1 && r_psel != PMAX)
                  w_psel_nxt = r_psel + PSEL_WIDTH'(1);
               else if (r_leader == 2'd2 && r_psel != '0)
                  w_psel_nxt = r_psel - PSEL_WIDTH'(1);
            end else begin
               w_age = 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // halt freezes every register, including the response outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_psel        <= PSEL_INIT;
         r_bip         <= '0;
         r_index       <= '0;
         r_policy      <= 1'b0;
         r_leader      <= 2'd0;
         r_victim      <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_victim <= '0;
         r_resp_policy <= 1'b0;
         r_resp_leader <= 2'd0;
         for (int s = 0; s < SETS; s++) r_rrpv[s] <= {WAYS{RMAX}};
      end else if (!halt) begin
         r_state      <= w_state_nxt;
         r_psel       <= w_psel_nxt;
         r_bip        <= w_bip_nxt;
         r_resp_valid <= (r_state == ST_DONE);
         if (w_accept) begin
            r_index  <= req_index;
            r_policy <= w_policy_in;
            r_leader <= w_leader_in;
            r_victim <= '0;
         end
         if (w_ins_wr) r_victim <= w_vic;
         if (r_state == ST_DONE) begin
            r_resp_victim <= r_victim;
            r_resp_policy <= r_policy;
            r_resp_leader <= r_leader;
         end
         for (int w = 0; w < WAYS; w++) begin
            if (w_hit_wr && req_hit_way[w]) r_rrpv[req_index][w] <= '0;
            if (w_ins_wr && w_vic[w])       r_rrpv[r_index][w]   <= w_ins_val;
            if (w_age)                      r_rrpv[r_index][w]   <= r_rrpv[r_index][w] + M'(1);
         end
      end
   end

endmodule

// File: tb/tb_drrip_dueling_ctrl.sv
// Directed bench for drrip_dueling_ctrl with immediate-assertion checks.
module tb_drrip_dueling_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       halt = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [5:0] req_index = '0;
   logic       req_hit = 1'b0;
   logic [3:0] req_hit_way = '0;
   logic       resp_valid;
   logic [3:0] resp_victim_way;
   logic       resp_policy;
   logic [1:0] resp_leader;
   logic [9:0] psel_o;

   int checks = 0;
   int errors = 0;

   drrip_dueling_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .halt            (halt),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_index       (req_index),
      .req_hit         (req_hit),
      .req_hit_way     (req_hit_way),
      .resp_valid      (resp_valid),
      .resp_victim_way (resp_victim_way),
      .resp_policy     (resp_policy),
      .resp_leader     (resp_leader),
      .psel_o          (psel_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] rr(input int s, input int w);
      return dut.r_rrpv[s][w];
   endfunction

   task automatic do_req(input logic [5:0] idx, input logic hit, input logic [3:0] way,
                         output int lat, output logic [3:0] vic, output logic pol,
                         output logic [1:0] lead);
      chk("req_ready_before", 32'(req_ready), 32'd1);
      req_valid   = 1'b1;
      req_index   = idx;
      req_hit     = hit;
      req_hit_way = way;
      step();
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         step();
         lat++;
      end
      if (!resp_valid) chk("resp_timeout", 32'(resp_valid), 32'd1);
      vic  = resp_victim_way;
      pol  = resp_policy;
      lead = resp_leader;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int         lat;
      logic [3:0] vic;
      logic       pol;
      logic [1:0] lead;
      logic [1:0] exp_rr;
      int         sets [4] = '{5, 9, 14, 20};

      // Reset values
      do_reset();
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_psel", 32'(psel_o), 32'd511);
      chk("rst_victim", 32'(resp_victim_way), 32'd0);
      chk("rst_policy", 32'(resp_policy), 32'd0);
      chk("rst_leader", 32'(resp_leader), 32'd0);

      // First follower miss on set 5
      do_req(6'b000101, 1'b0, 4'b0000, lat, vic, pol, lead);
      chk("t1_lat", 32'(lat), 32'd2);
      chk("t1_victim", 32'(vic), 32'h1);
      chk("t1_policy", 32'(pol), 32'd0);
      chk("t1_leader", 32'(lead), 32'd0);
      chk("t1_rrpv50", 32'(rr(5, 0)), 32'd2);

      // Fill remaining ways of set 5
      for (int w = 1; w < 4; w++) begin
         do_req(6'b000101, 1'b0, 4'b0000, lat, vic, pol, lead);
         chk("t2_fill_victim", 32'(vic), 32'(4'b0001 << w));
         chk("t2_fill_lat", 32'(lat), 32'd2);
      end
      for (int w = 0; w < 4; w++) chk("t2_fill_rrpv", 32'(rr(5, w)), 32'd2);

      // Hit way 2, then a miss needing one aging step
      do_req(6'b000101, 1'b1, 4'b0100, lat, vic, pol, lead);
      chk("t2_hit_lat", 32'(lat), 32'd1);
      chk("t2_hit_victim", 32'(vic), 32'd0);
      chk("t2_hit_rrpv", 32'(rr(5, 2)), 32'd0);
      do_req(6'b000101, 1'b0, 4'b0000, lat, vic, pol, lead);
      chk("t2_age_lat", 32'(lat), 32'd3);
      chk("t2_age_victim", 32'(vic), 32'h1);
      chk("t2_age_rrpv0", 32'(rr(5, 0)), 32'd2);
      chk("t2_age_rrpv1", 32'(rr(5, 1)), 32'd3);
      chk("t2_age_rrpv2", 32'(rr(5, 2)), 32'd1);
      chk("t2_age_rrpv3", 32'(rr(5, 3)), 32'd3);
      chk("t2_psel", 32'(psel_o), 32'd511);

      // SRRIP leader misses saturate PSEL at PMAX
      do_req(6'b001001, 1'b0, 4'b0000, lat, vic, pol, lead);
      chk("t3_leader", 32'(lead), 32'd1);
      chk("t3_policy", 32'(pol), 32'd0);
      chk("t3_psel1", 32'(psel_o), 32'd512);
      for (int i = 1; i < 512; i++) do_req(6'b001001, 1'b0, 4'b0000, lat, vic, pol, lead);
      chk("t3_psel512", 32'(psel_o), 32'd1023);
      for (int i = 512; i < 600; i++) do_req(6'b001001, 1'b0, 4'b0000, lat, vic, pol, lead);
      chk("t3_psel600", 32'(psel_o), 32'd1023);

      // Follower now uses BRRIP; set 5 is (2,3,1,3), bip_cnt 0
      do_req(6'b000101, 1'b0, 4'b0000, lat, vic, pol, lead);
      chk("t3_fol_policy", 32'(pol), 32'd1);
      chk("t3_fol_leader", 32'(lead), 32'd0);
      chk("t3_fol_victim", 32'(vic), 32'h2);
      chk("t3_fol_rrpv", 32'(rr(5, 1)), 32'd2);
      chk("t3_fol_psel", 32'(psel_o), 32'd1023);

      // BRRIP leader from reset: bimodal insertion and PSEL decrement
      do_reset();
      for (int k = 1; k <= 33; k++) begin
         do_req(6'b001110, 1'b0, 4'b0000, lat, vic, pol, lead);
         exp_rr = (k == 1 || k == 33) ? 2'd2 : 2'd3;
         chk("t4_victim", 32'(vic), (k == 1) ? 32'h1 : 32'h2);
         chk("t4_rrpv", 32'(rr(14, (k == 1) ? 0 : 1)), 32'(exp_rr));
         chk("t4_psel", 32'(psel_o), 32'(511 - k));
         if (k == 1) begin
            chk("t4_policy", 32'(pol), 32'd1);
            chk("t4_leader", 32'(lead), 32'd2);
         end
      end

      // halt for 5 cycles while in SCAN
      chk("t5_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_index = 6'b010100;
      req_hit   = 1'b0;
      step();
      req_valid = 1'b0;
      halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_halt_ready", 32'(req_ready), 32'd0);
         chk("t5_halt_valid", 32'(resp_valid), 32'd0);
         chk("t5_halt_rrpv", 32'(rr(20, 0)), 32'd3);
         chk("t5_halt_psel", 32'(psel_o), 32'd478);
      end
      halt = 1'b0;
      step();
      chk("t5_pre_valid", 32'(resp_valid), 32'd0);
      step();
      chk("t5_valid", 32'(resp_valid), 32'd1);
      chk("t5_victim", 32'(resp_victim_way), 32'h1);
      chk("t5_policy", 32'(resp_policy), 32'd0);
      chk("t5_rrpv", 32'(rr(20, 0)), 32'd2);

      // Reset in the middle of a SCAN abandons it
      step();
      req_valid = 1'b1;
      req_index = 6'b001001;
      req_hit   = 1'b0;
      step();
      req_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_resp", 32'(resp_valid), 32'd0);
      end
      chk("t6_psel", 32'(psel_o), 32'd511);
      for (int s = 0; s < 4; s++)
         for (int w = 0; w < 4; w++) chk("t6_rrpv", 32'(rr(sets[s], w)), 32'd3);

      // A request held during DONE is not accepted
      req_valid   = 1'b1;
      req_index   = 6'b000101;
      req_hit     = 1'b1;
      req_hit_way = 4'b0010;
      step();
      req_hit_way = 4'b1000;
      chk("t6_done_ready", 32'(req_ready), 32'd0);
      step();
      req_valid = 1'b0;
      chk("t6_hit_valid", 32'(resp_valid), 32'd1);
      chk("t6_hit_victim", 32'(resp_victim_way), 32'd0);
      step();
      chk("t6_hit_rrpv1", 32'(rr(5, 1)), 32'd0);
      chk("t6_ignored_rrpv3", 32'(rr(5, 3)), 32'd3);
      chk("t6_valid_drop", 32'(resp_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
